// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Types and constants shared by mem_arbiter and arb_tag_pipe.
//   owner_e        : which requester a memory access belongs to.
//   mem_req_t      : one memory access (write enable, address, data, strobes).
//   ARB_MAX_WAIT_W : width of the instruction-port starvation counter.
//   ARB_ADDR_W     : address width carried in mem_req_t; the top-level ADDR_W
//                    must not exceed it.
//   sat_inc()      : saturating increment used by the starvation counter.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;
    import pkg_parameters::*;

    localparam int ARB_MAX_WAIT_W = 4;
    localparam int ARB_ADDR_W     = 32;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       wdata;
        logic [XLEN/8-1:0]     wstrb;
    } mem_req_t;

    function automatic logic [ARB_MAX_WAIT_W-1:0] sat_inc(
        input logic [ARB_MAX_WAIT_W-1:0] val,
        input logic [ARB_MAX_WAIT_W-1:0] max_val
    );
        return (val >= max_val) ? max_val : val + ARB_MAX_WAIT_W'(1);
    endfunction
endpackage

// File: rtl/pkg_parameters.sv
// -----------------------------------------------------------------------------
// pkg_parameters
//   Core-wide parameters shared by the cpu and its memory-side blocks.
//   XLEN : data path width in bits (byte enables are XLEN/8 wide).
// -----------------------------------------------------------------------------
package pkg_parameters;
    localparam int XLEN = 32;
endpackage

// File: rtl/arb_tag_pipe.sv
// -----------------------------------------------------------------------------
// arb_tag_pipe
//   DEPTH-deep shift register of {valid, owner} tags. A tag pushed in the
//   cycle a read is issued leaves the last stage exactly DEPTH cycles later,
//   i.e. in the cycle the memory presents that read's data.
//
// Ports
//   clk_i    in   clock
//   rst_i    in   asynchronous active-low reset, clears every stage
//   push_i   in   a read is being issued this cycle
//   owner_i  in   owner of that read (OWN_I / OWN_D)
//   valid_o  out  a tagged read's data is on the memory bus this cycle
//   owner_o  out  owner of that data
// -----------------------------------------------------------------------------
module arb_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic owner_i,
    output logic valid_o,
    output logic owner_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] own_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q <= '0;
            own_q <= OWN_I;
        end else begin
            vld_q[0] <= push_i;
            own_q[0] <= owner_i;
            for (int k = 1; k < int'(DEPTH); k++) begin
                vld_q[k] <= vld_q[k-1];
                own_q[k] <= own_q[k-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign owner_o = own_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous memory between instruction fetch
//   (port I) and load/store (port D). D has fixed priority, except that once
//   I has lost MAX_WAIT consecutive cycles it is force-granted. Every issued
//   read is tagged with its owner so the returning data is steered back.
//
// Parameters
//   ADDR_W   byte address width (<= ARB_ADDR_W)
//   RD_LAT   memory read latency, 1 or 2
//   MAX_WAIT consecutive I losses before a forced I grant, 1..15
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-low reset
//   i_valid_i/i_ready_o       fetch request / accepted this cycle
//   i_addr_i                  fetch address
//   i_rvalid_o/i_rdata_o      fetch data return
//   d_valid_i/d_ready_o       load/store request / accepted this cycle
//   d_we_i, d_addr_i,
//   d_wdata_i, d_wstrb_i      load/store fields
//   d_rvalid_o/d_rdata_o      load data return
//   mem_en_o, mem_we_o,
//   mem_addr_o, mem_wdata_o,
//   mem_wstrb_o               memory access (driven in the grant cycle)
//   mem_rdata_i               memory read data, RD_LAT cycles after issue
//
// Handshake: a request transfers in any cycle where valid && ready. Ready is
// combinational from this cycle's valids; requesters hold valid and fields
// stable until accepted, and may drop an unaccepted request at any time.
//
// Optional feature (macro ARB_PERF_CNT_EN): adds 32-bit wrapping counters
//   perf_conflict_o  cycles with both valids high
//   perf_starve_o    forced I grants
// -----------------------------------------------------------------------------
module mem_arbiter
    import pkg_parameters::*;
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_valid_i,
    output logic              i_ready_o,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_rvalid_o,
    output logic [XLEN-1:0]   i_rdata_o,
    input  logic              d_valid_i,
    output logic              d_ready_o,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [XLEN-1:0]   d_wdata_i,
    input  logic [XLEN/8-1:0] d_wstrb_i,
    output logic              d_rvalid_o,
    output logic [XLEN-1:0]   d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wstrb_o,
    input  logic [XLEN-1:0]   mem_rdata_i
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_conflict_o,
    output logic [31:0]       perf_starve_o
`endif
);

    localparam logic [ARB_MAX_WAIT_W-1:0] MAX_WAIT_C = ARB_MAX_WAIT_W'(MAX_WAIT);

    logic [ARB_MAX_WAIT_W-1:0] wait_q;
    logic [ARB_MAX_WAIT_W-1:0] wait_d;

    logic     i_starved;
    logic     grant_i;
    logic     grant_d;
    logic     issue_rd;
    mem_req_t req_i;
    mem_req_t req_d;
    mem_req_t req_win;
    logic     tag_valid;
    logic     tag_owner;

    // Raw grants feed the state (wait counter, tag pipe); the ports below are
    // additionally masked by reset so every output reads 0 while rst_i is low,
    // even if requesters keep their valids up.
    always_comb begin
        i_starved = i_valid_i && (wait_q == MAX_WAIT_C);
        grant_d   = d_valid_i && !i_starved;
        grant_i   = i_valid_i && !grant_d;
    end

    always_comb begin
        req_i       = '0;
        req_i.addr  = ARB_ADDR_W'(i_addr_i);

        req_d       = '0;
        req_d.we    = d_we_i;
        req_d.addr  = ARB_ADDR_W'(d_addr_i);
        req_d.wdata = d_wdata_i;
        req_d.wstrb = d_wstrb_i;

        req_win = '0;
        if (rst_i) begin
            if (grant_d) begin
                req_win = req_d;
            end else if (grant_i) begin
                req_win = req_i;
            end
        end
    end

    assign i_ready_o   = rst_i && grant_i;
    assign d_ready_o   = rst_i && grant_d;
    assign mem_en_o    = i_ready_o || d_ready_o;
    assign mem_we_o    = req_win.we;
    assign mem_addr_o  = ADDR_W'(req_win.addr);
    assign mem_wdata_o = req_win.wdata;
    assign mem_wstrb_o = req_win.wstrb;

    // Consecutive-loss counter: any I grant or a dropped I request restarts it.
    always_comb begin
        wait_d = wait_q;
        if (!i_valid_i || grant_i) begin
            wait_d = '0;
        end else begin
            wait_d = sat_inc(wait_q, MAX_WAIT_C);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // Only reads are tagged; stores never return data.
    assign issue_rd = (grant_d && !d_we_i) || grant_i;

    arb_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (issue_rd),
        .owner_i (grant_d ? OWN_D : OWN_I),
        .valid_o (tag_valid),
        .owner_o (tag_owner)
    );

    assign i_rvalid_o = tag_valid && (tag_owner == OWN_I);
    assign d_rvalid_o = tag_valid && (tag_owner == OWN_D);
    assign i_rdata_o  = i_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_starve_q;

    // A forced grant is a starved I beating a pending D request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_conflict_q <= '0;
            perf_starve_q   <= '0;
        end else begin
            if (i_valid_i && d_valid_i) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
            if (i_starved && d_valid_i) begin
                perf_starve_q <= perf_starve_q + 32'd1;
            end
        end
    end

    assign perf_conflict_o = perf_conflict_q;
    assign perf_starve_o   = perf_starve_q;
`endif

endmodule
